// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: FSM encoding and
// timing constants for silicon and for scaled-down simulation.
package btn_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE       = 2'd0,
        BTN_PRESS_DB   = 2'd1,
        BTN_HELD       = 2'd2,
        BTN_RELEASE_DB = 2'd3
    } btn_state_t;

    // 10 ms debounce and 1 s long-press at 125 MHz
    localparam int BTN_DEBOUNCE_DEFAULT = 1_250_000;
    localparam int BTN_LONG_DEFAULT     = 125_000_000;
    localparam int BTN_CNT_W_DEFAULT    = 27;

    localparam int BTN_DEBOUNCE_SIM = 4;
    localparam int BTN_LONG_SIM     = 20;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; both stages clear to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/btn_event_decoder.sv
// Push-button conditioner: synchronise, debounce both edges, and decode into a
// stable level plus one-cycle press / release / click / long-press pulses.
module btn_event_decoder
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
    parameter int LONG_CYCLES     = BTN_LONG_DEFAULT,
    parameter int CNT_W           = BTN_CNT_W_DEFAULT
) (
    input  logic clk125_i,
    input  logic reset_n,
    input  logic btn_in,
    output logic btn_level_o,
    output logic press_o,
    output logic release_o,
    output logic click_o,
    output logic long_o
);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);

    logic             btn_s;
    btn_state_t       state;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_inc;
    logic             long_done;

    sync_2ff u_sync (
        .clk   (clk125_i),
        .rst_n (reset_n),
        .d     (btn_in),
        .q     (btn_s)
    );

    assign hold_inc = (hold_cnt == LONG_MAX) ? hold_cnt : hold_cnt + CNT_ONE;

    // The sample that leaves IDLE/HELD already counts as the first stable one,
    // so db_cnt starts at 1 and a change is accepted after DEBOUNCE_CYCLES samples.
    always_ff @(posedge clk125_i or negedge reset_n) begin
        if (!reset_n) begin
            state       <= BTN_IDLE;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            long_done   <= 1'b0;
            btn_level_o <= 1'b0;
            press_o     <= 1'b0;
            release_o   <= 1'b0;
            click_o     <= 1'b0;
            long_o      <= 1'b0;
        end else begin
            press_o   <= 1'b0;
            release_o <= 1'b0;
            click_o   <= 1'b0;
            long_o    <= 1'b0;
            case (state)
                BTN_IDLE: begin
                    if (btn_s) begin
                        state  <= BTN_PRESS_DB;
                        db_cnt <= CNT_ONE;
                    end
                end
                BTN_PRESS_DB: begin
                    if (!btn_s) begin
                        state <= BTN_IDLE;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= BTN_HELD;
                        btn_level_o <= 1'b1;
                        press_o     <= 1'b1;
                        hold_cnt    <= '0;
                        long_done   <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + CNT_ONE;
                    end
                end
                BTN_HELD: begin
                    if (!btn_s) begin
                        state  <= BTN_RELEASE_DB;
                        db_cnt <= CNT_ONE;
                    end else begin
                        hold_cnt <= hold_inc;
                        if (hold_inc == LONG_LAST && !long_done) begin
                            long_o    <= 1'b1;
                            long_done <= 1'b1;
                        end
                    end
                end
                BTN_RELEASE_DB: begin
                    // hold_cnt stays frozen for the whole dip, including the return sample
                    if (btn_s) begin
                        state <= BTN_HELD;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= BTN_IDLE;
                        btn_level_o <= 1'b0;
                        release_o   <= 1'b1;
                        click_o     <= !long_done;
                    end else begin
                        db_cnt <= db_cnt + CNT_ONE;
                    end
                end
                default: state <= BTN_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_event_decoder.sv
// Bench for btn_event_decoder: directed run-length tables plus random stimulus
// against a sample-counting reference model.
module tb_btn_event_decoder;
    import btn_pkg::*;

    localparam int D = BTN_DEBOUNCE_SIM;
    localparam int L = BTN_LONG_SIM;

    logic clk = 1'b0;
    logic reset_n;
    logic btn_in;
    logic btn_level_o, press_o, release_o, click_o, long_o;

    always #4 clk = ~clk;

    btn_event_decoder #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .CNT_W           (8)
    ) dut (
        .clk125_i    (clk),
        .reset_n     (reset_n),
        .btn_in      (btn_in),
        .btn_level_o (btn_level_o),
        .press_o     (press_o),
        .release_o   (release_o),
        .click_o     (click_o),
        .long_o      (long_o)
    );

    // expected vector = {level, press, release, click, long}
    typedef struct {
        logic       btn;
        int         reps;
        logic [4:0] exp;
    } seg_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: counts synchronised samples that disagree with the
    // accepted level, and samples spent high while the level is high.
    logic       m_h1, m_h2;
    logic       m_level;
    int         m_run;
    int         m_held;
    logic       m_long_fired;
    logic [4:0] m_exp;

    task automatic model_reset();
        m_h1 = 0; m_h2 = 0; m_level = 0; m_run = 0; m_held = 0;
        m_long_fired = 0; m_exp = 5'b0;
    endtask

    task automatic model_step();
        logic s;
        logic p, r, c, lg;
        s = m_h2;
        p = 0; r = 0; c = 0; lg = 0;
        if (s != m_level) begin
            m_run++;
            if (m_run == D) begin
                m_level = s;
                m_run = 0;
                if (s) begin
                    p = 1; m_held = 0; m_long_fired = 0;
                end else begin
                    r = 1; c = !m_long_fired;
                end
            end
        end else begin
            if (m_run == 0 && m_level) begin
                m_held++;
                if (m_held == L - 1 && !m_long_fired) begin
                    lg = 1; m_long_fired = 1;
                end
            end
            m_run = 0;
        end
        m_h2 = m_h1;
        m_h1 = btn_in;
        m_exp = {m_level, p, r, c, lg};
    endtask

    task automatic check(input logic [4:0] exp, input string tag);
        logic [4:0] got;
        got = {btn_level_o, press_o, release_o, click_o, long_o};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got lvl/prs/rel/clk/lng=%b required=%b at %0t", tag, got, exp, $time);
        end
    endtask

    // called at a negedge with btn_in already set; returns at the next negedge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic run_table(input seg_t tbl[], input string tag);
        foreach (tbl[k]) begin
            for (int i = 0; i < tbl[k].reps; i++) begin
                btn_in = tbl[k].btn;
                tick();
                check(tbl[k].exp, tag);
            end
        end
    endtask

    seg_t t_press_after_rst[];
    seg_t t_idle[];
    seg_t t_short[];
    seg_t t_glitch[];
    seg_t t_bouncy[];
    seg_t t_long[];

    initial begin
        t_press_after_rst = '{'{1, 5, 5'b00000}, '{1, 1, 5'b11000}, '{1, 2, 5'b10000}};
        t_idle   = '{'{0, 4, 5'b00000}};
        t_short  = '{'{1, 5, 5'b00000}, '{1, 1, 5'b11000}, '{1, 4, 5'b10000},
                     '{0, 5, 5'b10000}, '{0, 1, 5'b00110}, '{0, 3, 5'b00000}};
        t_glitch = '{'{1, 3, 5'b00000}, '{0, 20, 5'b00000}};
        t_bouncy = '{'{1, 5, 5'b00000}, '{1, 1, 5'b11000}, '{1, 2, 5'b10000},
                     '{0, 2, 5'b10000}, '{1, 2, 5'b10000},
                     '{0, 5, 5'b10000}, '{0, 1, 5'b00110}, '{0, 3, 5'b00000}};
        t_long   = '{'{1, 5, 5'b00000}, '{1, 1, 5'b11000}, '{1, 18, 5'b10000},
                     '{1, 1, 5'b10001}, '{1, 15, 5'b10000},
                     '{0, 5, 5'b10000}, '{0, 1, 5'b00100}, '{0, 3, 5'b00000}};

        // reset with the button already held
        reset_n = 1'b0;
        btn_in  = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check(5'b0, "reset_held");
        end
        reset_n = 1'b1;
        run_table(t_press_after_rst, "press_after_reset");

        // reset mid-hold: outputs must clear without a clock edge
        #2;
        reset_n = 1'b0;
        #1;
        check(5'b0, "async_reset");
        model_reset();
        btn_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check(5'b0, "reset_no_release");
        end
        reset_n = 1'b1;

        run_table(t_idle,   "idle");
        run_table(t_short,  "short_press");
        run_table(t_glitch, "glitch");
        run_table(t_bouncy, "bouncy_release");
        run_table(t_long,   "long_press");

        // random segments, mixing bounce-length glitches with longer holds
        for (int seg = 0; seg < 200; seg++) begin
            int len;
            logic b;
            b = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                              : int'($urandom_range(1, 30));
            for (int i = 0; i < len; i++) begin
                btn_in = b;
                tick();
                check(m_exp, "random");
            end
        end
        btn_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check(m_exp, "random_flush");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
